terminal_scroll_controller: RTL and testbench

Parametrised successor to the terminal input controller. It turns a stream of already-ASCII-encoded edit commands into single-port text-buffer writes (`tg_we`/`tg_addr`/`tg_input`) for the text generator. Over the previous controller it adds:
- any screen geometry;
- a valid/ready command handshake;
- automatic line wrap;
- hardware scrolling through a circular row base, with multi-cycle row clear and full-screen clear;
- a one-deep queued status-message writer for a dedicated status row.

---
 rtl/terminal_scroll_controller.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_terminal_scroll_controller.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/terminal_scroll_controller.sv
// rtl/terminal_scroll_controller.sv - edit-command to text-buffer writer with wrap, circular scroll and status row
module terminal_scroll_controller #(
    parameter int SCREEN_WIDTH  = 76,
    parameter int SCREEN_HEIGHT = 44,
    parameter int STATUS_COL    = 0,
    parameter int MSG_LEN       = 8
) (
    input  logic                                        pixel_clk_in,
    input  logic                                        rst_in,
    input  logic                                        cmd_valid,
    output logic                                        cmd_ready,
    input  logic [1:0]                                  cmd_op,
    input  logic [7:0]                                  cmd_char,
    input  logic                                        status_valid,
    input  logic [1:0]                                  status_sel,
    output logic                                        tg_we,
    output logic [$clog2(SCREEN_WIDTH*SCREEN_HEIGHT)-1:0] tg_addr,
    output logic [7:0]                                  tg_input,
    output logic [$clog2(SCREEN_WIDTH)-1:0]             cursor_x,
    output logic [$clog2(SCREEN_HEIGHT-2)-1:0]          cursor_y,
    output logic [$clog2(SCREEN_HEIGHT-2)-1:0]          row_base,
    output logic                                        busy
);

    localparam int TEXT_ROWS = SCREEN_HEIGHT - 2;
    localparam int AW        = $clog2(SCREEN_WIDTH*SCREEN_HEIGHT);
    localparam int XW        = $clog2(SCREEN_WIDTH);
    localparam int YW        = $clog2(TEXT_ROWS);
    localparam int SW        = YW + 1;

    localparam logic [XW-1:0] X_LAST      = XW'(SCREEN_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST      = YW'(TEXT_ROWS - 1);
    localparam logic [SW-1:0] ROWS_S      = SW'(TEXT_ROWS);
    localparam logic [AW-1:0] ROW_LEN     = AW'(SCREEN_WIDTH);
    localparam logic [AW-1:0] ROW_END     = AW'(SCREEN_WIDTH - 1);
    localparam logic [AW-1:0] TEXT_END    = AW'(TEXT_ROWS*SCREEN_WIDTH - 1);
    localparam logic [AW-1:0] STATUS_BASE = AW'(TEXT_ROWS*SCREEN_WIDTH + STATUS_COL);
    localparam logic [AW-1:0] MSG_END     = AW'(MSG_LEN - 1);
    localparam logic [7:0]    SPACE       = 8'h20;

    localparam logic [1:0] OP_INSERT  = 2'd0;
    localparam logic [1:0] OP_NEWLINE = 2'd1;
    localparam logic [1:0] OP_BKSP    = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_CLR_ROW,
        S_CLR_ALL,
        S_STATUS
    } state_t;

    state_t        state, state_n;
    logic          we_n;
    logic [AW-1:0] addr_n;
    logic [7:0]    data_n;
    logic [XW-1:0] cx_n;
    logic [YW-1:0] cy_n, base_n;
    logic [AW-1:0] cnt, cnt_n;
    logic [AW-1:0] clr_base, clr_base_n;
    logic          wrap_clear, wrap_clear_n;
    logic          status_pending, pend_n;
    logic [1:0]    pend_sel, pend_sel_n;
    logic [1:0]    run_sel, run_sel_n;

    // Logical row to physical row: base+y wraps at most once, so one subtract suffices.
    function automatic logic [YW-1:0] phys_row(input logic [YW-1:0] base, input logic [YW-1:0] y);
        logic [SW-1:0] sum;
        sum = {1'b0, base} + {1'b0, y};
        if (sum >= ROWS_S) begin
            sum = sum - ROWS_S;
        end
        return sum[YW-1:0];
    endfunction

    function automatic logic [AW-1:0] row_addr(input logic [YW-1:0] phys);
        return AW'(phys) * ROW_LEN;
    endfunction

    function automatic logic [AW-1:0] cell_addr(input logic [YW-1:0] base, input logic [YW-1:0] y,
                                                input logic [XW-1:0] x);
        return row_addr(phys_row(base, y)) + AW'(x);
    endfunction

    function automatic logic [YW-1:0] next_base(input logic [YW-1:0] b);
        return (b == Y_LAST) ? '0 : b + YW'(1);
    endfunction

    // Status message ROM; characters beyond the eighth are padded with spaces.
    function automatic logic [7:0] msg_char(input logic [1:0] sel, input logic [AW-1:0] idx);
        logic [63:0] text;
        logic [7:0]  ch;
        case (sel)
            2'd0:    text = "        ";
            2'd1:    text = " compile";
            2'd2:    text = " idling ";
            default: text = " error  ";
        endcase
        if (idx < AW'(8)) begin
            ch = text[{~idx[2:0], 3'b000} +: 8];
        end else begin
            ch = SPACE;
        end
        return ch;
    endfunction

    assign cmd_ready = (state == S_IDLE) && !status_pending;
    assign busy      = (state != S_IDLE);

    // Next-state, next write slot, cursor/scroll and status-queue updates.
    always_comb begin
        state_n      = state;
        we_n         = 1'b0;
        addr_n       = tg_addr;
        data_n       = tg_input;
        cx_n         = cursor_x;
        cy_n         = cursor_y;
        base_n       = row_base;
        cnt_n        = cnt;
        clr_base_n   = clr_base;
        wrap_clear_n = wrap_clear;
        pend_n       = status_pending;
        pend_sel_n   = pend_sel;
        run_sel_n    = run_sel;

        case (state)
            S_IDLE: begin
                if (status_pending) begin
                    state_n   = S_STATUS;
                    we_n      = 1'b1;
                    addr_n    = STATUS_BASE;
                    data_n    = msg_char(pend_sel, '0);
                    cnt_n     = '0;
                    run_sel_n = pend_sel;
                    pend_n    = 1'b0;
                end else if (cmd_valid) begin
                    case (cmd_op)
                        OP_INSERT: begin
                            state_n      = S_WRITE;
                            wrap_clear_n = 1'b0;
                            we_n         = 1'b1;
                            addr_n       = cell_addr(row_base, cursor_y, cursor_x);
                            data_n       = cmd_char;
                            if (cursor_x < X_LAST) begin
                                cx_n = cursor_x + XW'(1);
                            end else begin
                                cx_n = '0;
                                if (cursor_y < Y_LAST) begin
                                    cy_n = cursor_y + YW'(1);
                                end else begin
                                    base_n       = next_base(row_base);
                                    clr_base_n   = row_addr(row_base);
                                    wrap_clear_n = 1'b1;
                                end
                            end
                        end
                        OP_NEWLINE: begin
                            cx_n = '0;
                            if (cursor_y < Y_LAST) begin
                                cy_n         = cursor_y + YW'(1);
                                state_n      = S_WRITE;
                                wrap_clear_n = 1'b0;
                            end else begin
                                // The old top row becomes the new bottom row and is blanked.
                                base_n  = next_base(row_base);
                                state_n = S_CLR_ROW;
                                we_n    = 1'b1;
                                addr_n  = row_addr(row_base);
                                data_n  = SPACE;
                                cnt_n   = '0;
                            end
                        end
                        OP_BKSP: begin
                            state_n      = S_WRITE;
                            wrap_clear_n = 1'b0;
                            if (cursor_x != '0) begin
                                cx_n   = cursor_x - XW'(1);
                                we_n   = 1'b1;
                                addr_n = cell_addr(row_base, cursor_y, cursor_x - XW'(1));
                                data_n = SPACE;
                            end else if (cursor_y != '0) begin
                                cx_n   = X_LAST;
                                cy_n   = cursor_y - YW'(1);
                                we_n   = 1'b1;
                                addr_n = cell_addr(row_base, cursor_y - YW'(1), X_LAST);
                                data_n = SPACE;
                            end
                        end
                        default: begin
                            state_n = S_CLR_ALL;
                            we_n    = 1'b1;
                            addr_n  = '0;
                            data_n  = SPACE;
                            cnt_n   = '0;
                        end
                    endcase
                end
            end
            S_WRITE: begin
                if (wrap_clear) begin
                    state_n      = S_CLR_ROW;
                    wrap_clear_n = 1'b0;
                    we_n         = 1'b1;
                    addr_n       = clr_base;
                    data_n       = SPACE;
                    cnt_n        = '0;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_CLR_ROW: begin
                if (cnt == ROW_END) begin
                    state_n = S_IDLE;
                end else begin
                    we_n   = 1'b1;
                    addr_n = tg_addr + AW'(1);
                    data_n = SPACE;
                    cnt_n  = cnt + AW'(1);
                end
            end
            S_CLR_ALL: begin
                if (cnt == TEXT_END) begin
                    state_n = S_IDLE;
                    cx_n    = '0;
                    cy_n    = '0;
                    base_n  = '0;
                end else begin
                    we_n   = 1'b1;
                    addr_n = tg_addr + AW'(1);
                    data_n = SPACE;
                    cnt_n  = cnt + AW'(1);
                end
            end
            S_STATUS: begin
                if (cnt == MSG_END) begin
                    state_n = S_IDLE;
                end else begin
                    we_n   = 1'b1;
                    addr_n = tg_addr + AW'(1);
                    data_n = msg_char(run_sel, cnt + AW'(1));
                    cnt_n  = cnt + AW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // A new request always wins, even over the clear-on-entry above.
        if (status_valid) begin
            pend_n     = 1'b1;
            pend_sel_n = status_sel;
        end
    end

    // FSM state register.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Registered write port, cursor, scroll base and status queue.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            tg_we          <= 1'b0;
            tg_addr        <= '0;
            tg_input       <= '0;
            cursor_x       <= '0;
            cursor_y       <= '0;
            row_base       <= '0;
            cnt            <= '0;
            clr_base       <= '0;
            wrap_clear     <= 1'b0;
            status_pending <= 1'b0;
            pend_sel       <= '0;
            run_sel        <= '0;
        end else begin
            tg_we          <= we_n;
            tg_addr        <= addr_n;
            tg_input       <= data_n;
            cursor_x       <= cx_n;
            cursor_y       <= cy_n;
            row_base       <= base_n;
            cnt            <= cnt_n;
            clr_base       <= clr_base_n;
            wrap_clear     <= wrap_clear_n;
            status_pending <= pend_n;
            pend_sel       <= pend_sel_n;
            run_sel        <= run_sel_n;
        end
    end

endmodule

// File: tb/tb_terminal_scroll_controller.sv
// tb/tb_terminal_scroll_controller.sv - randomized self-checking bench with a slot-queue reference model
module tb_terminal_scroll_controller;

    localparam int W     = 76;
    localparam int TR    = 42;
    localparam int CELLS = TR * W;
    localparam int MSGN  = 8;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [7:0]  cmd_char = 8'd0;
    logic        status_valid = 1'b0;
    logic [1:0]  status_sel = 2'd0;
    logic        tg_we;
    logic [11:0] tg_addr;
    logic [7:0]  tg_input;
    logic [6:0]  cursor_x;
    logic [5:0]  cursor_y;
    logic [5:0]  row_base;
    logic        busy;

    always #5 clk = ~clk;

    terminal_scroll_controller dut (
        .pixel_clk_in (clk),
        .rst_in       (rst_in),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_char     (cmd_char),
        .status_valid (status_valid),
        .status_sel   (status_sel),
        .tg_we        (tg_we),
        .tg_addr      (tg_addr),
        .tg_input     (tg_input),
        .cursor_x     (cursor_x),
        .cursor_y     (cursor_y),
        .row_base     (row_base),
        .busy         (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;
    bit rnd_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: every accepted command or status becomes a list of one-cycle slots.
    typedef struct {
        bit we;
        int addr;
        int data;
        bit clr_cur;
    } slot_t;

    slot_t q[$];
    slot_t cur;
    bit    cur_valid = 0;
    int    mx = 0, my = 0, mb = 0;
    bit    mpend = 0;
    int    msel = 0;
    string msgs[4];

    initial begin
        msgs[0] = "        ";
        msgs[1] = " compile";
        msgs[2] = " idling ";
        msgs[3] = " error  ";
    end

    function automatic int addr_of(int b, int y, int x);
        return ((b + y) % TR) * W + x;
    endfunction

    task automatic push(input bit we, input int a, input int d, input bit c);
        slot_t s;
        s.we = we;
        s.addr = a;
        s.data = d;
        s.clr_cur = c;
        q.push_back(s);
    endtask

    task automatic row_advance();
        int old;
        if (my < TR - 1) begin
            my++;
        end else begin
            old = mb;
            mb = (mb + 1) % TR;
            for (int c = 0; c < W; c++) push(1, old * W + c, 8'h20, 0);
        end
    endtask

    task automatic build_cmd(input int op, input int ch);
        case (op)
            0: begin
                push(1, addr_of(mb, my, mx), ch, 0);
                if (mx < W - 1) mx++;
                else begin
                    mx = 0;
                    row_advance();
                end
            end
            1: begin
                mx = 0;
                if (my < TR - 1) begin
                    my++;
                    push(0, 0, 0, 0);
                end else begin
                    row_advance();
                end
            end
            2: begin
                if (mx == 0 && my == 0) begin
                    push(0, 0, 0, 0);
                end else begin
                    if (mx > 0) mx--;
                    else begin
                        mx = W - 1;
                        my--;
                    end
                    push(1, addr_of(mb, my, mx), 8'h20, 0);
                end
            end
            default: begin
                for (int a = 0; a < CELLS; a++) push(1, a, 8'h20, a == CELLS - 1);
            end
        endcase
    endtask

    task automatic model_step();
        if (rst_in) begin
            q.delete();
            cur_valid = 0;
            mx = 0; my = 0; mb = 0;
            mpend = 0; msel = 0;
            return;
        end
        if (cur_valid) begin
            if (cur.clr_cur) begin
                mx = 0; my = 0; mb = 0;
            end
            if (q.size() > 0) cur = q.pop_front();
            else cur_valid = 0;
        end else if (mpend) begin
            for (int i = 0; i < MSGN; i++) push(1, CELLS + i, msgs[msel][i], 0);
            mpend = 0;
            cur = q.pop_front();
            cur_valid = 1;
        end else if (cmd_valid) begin
            build_cmd(int'(cmd_op), int'(cmd_char));
            cur = q.pop_front();
            cur_valid = 1;
        end
        if (status_valid) begin
            mpend = 1;
            msel = int'(status_sel);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison of every DUT output against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            bit exp_we;
            exp_we = cur_valid && cur.we;
            check("tg_we", 32'(tg_we), 32'(exp_we));
            if (exp_we) begin
                check("tg_addr", 32'(tg_addr), cur.addr);
                check("tg_input", 32'(tg_input), cur.data);
            end
            check("cursor_x", 32'(cursor_x), mx);
            check("cursor_y", 32'(cursor_y), my);
            check("row_base", 32'(row_base), mb);
            check("busy", 32'(busy), 32'(cur_valid));
            check("cmd_ready", 32'(cmd_ready), 32'(!cur_valid && !mpend));
        end
    end

    initial forever begin
        @(negedge clk);
        if (rnd_en) begin
            status_valid = ($urandom_range(0, 39) == 0);
            status_sel = 2'($urandom_range(0, 3));
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst_in = 1'b1;
        cmd_valid = 1'b0;
        status_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_in = 1'b0;
    endtask

    // Offers one command, returns at the negedge of the cycle after acceptance.
    task automatic send(input logic [1:0] op, input logic [7:0] ch);
        int t;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_char = ch;
        t = 0;
        while (!cmd_ready && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("handshake_bound", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        string smsg;
        int t;
        int nclr;
        int r;
        logic [1:0] op;

        smsg = " compile";
        repeat (3) @(negedge clk);
        rst_in = 1'b0;
        chk_en = 1;

        // Reset state
        check("rst_tg_we", 32'(tg_we), 0);
        check("rst_tg_addr", 32'(tg_addr), 0);
        check("rst_tg_input", 32'(tg_input), 0);
        check("rst_cursor_x", 32'(cursor_x), 0);
        check("rst_cursor_y", 32'(cursor_y), 0);
        check("rst_row_base", 32'(row_base), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_cmd_ready", 32'(cmd_ready), 1);

        // Insert after reset
        send(2'd0, 8'h61);
        check("ins_we", 32'(tg_we), 1);
        check("ins_addr", 32'(tg_addr), 0);
        check("ins_data", 32'(tg_input), 32'h61);
        check("ins_cx", 32'(cursor_x), 1);
        check("ins_cy", 32'(cursor_y), 0);
        check("ins_ready_n1", 32'(cmd_ready), 0);
        @(negedge clk);
        check("ins_ready_n2", 32'(cmd_ready), 1);

        // Line wrap then backspace across rows
        for (int i = 0; i < 75; i++) send(2'd0, 8'(8'h41 + i % 26));
        check("wrap_addr", 32'(tg_addr), 75);
        check("wrap_cx", 32'(cursor_x), 0);
        check("wrap_cy", 32'(cursor_y), 1);
        send(2'd2, 8'h00);
        check("bksp_row_we", 32'(tg_we), 1);
        check("bksp_row_addr", 32'(tg_addr), 75);
        check("bksp_row_data", 32'(tg_input), 32'h20);
        check("bksp_row_cx", 32'(cursor_x), 75);
        check("bksp_row_cy", 32'(cursor_y), 0);

        // Backspace at origin
        apply_reset();
        send(2'd2, 8'h00);
        check("bksp0_we", 32'(tg_we), 0);
        check("bksp0_busy", 32'(busy), 1);
        check("bksp0_cx", 32'(cursor_x), 0);
        check("bksp0_cy", 32'(cursor_y), 0);

        // Scroll with a status request landing mid-clear and a command held waiting
        for (int i = 0; i < 41; i++) send(2'd1, 8'h00);
        check("pre_scroll_cy", 32'(cursor_y), 41);
        @(negedge clk);
        check("scroll_ready", 32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_op = 2'd1;
        @(negedge clk);
        cmd_op = 2'd0;
        cmd_char = 8'h5a;
        check("scroll_base", 32'(row_base), 1);
        check("scroll_cx", 32'(cursor_x), 0);
        check("scroll_cy", 32'(cursor_y), 41);
        for (int i = 0; i < W; i++) begin
            check("scroll_clr_we", 32'(tg_we), 1);
            check("scroll_clr_addr", 32'(tg_addr), i);
            check("scroll_clr_data", 32'(tg_input), 32'h20);
            check("scroll_clr_ready", 32'(cmd_ready), 0);
            if (i == 10) begin
                status_valid = 1'b1;
                status_sel = 2'd1;
            end
            if (i == 11) status_valid = 1'b0;
            @(negedge clk);
        end
        check("gap_we", 32'(tg_we), 0);
        check("gap_ready", 32'(cmd_ready), 0);
        @(negedge clk);
        for (int j = 0; j < MSGN; j++) begin
            check("status_we", 32'(tg_we), 1);
            check("status_addr", 32'(tg_addr), 3192 + j);
            check("status_data", 32'(tg_input), 32'(smsg[j]));
            check("status_ready", 32'(cmd_ready), 0);
            @(negedge clk);
        end
        check("held_cmd_ready", 32'(cmd_ready), 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("held_cmd_we", 32'(tg_we), 1);
        check("held_cmd_addr", 32'(tg_addr), 0);
        check("held_cmd_data", 32'(tg_input), 32'h5a);
        check("held_cmd_cx", 32'(cursor_x), 1);

        // Full clear
        send(2'd3, 8'h00);
        check("clr_first_addr", 32'(tg_addr), 0);
        check("clr_first_we", 32'(tg_we), 1);
        t = 0;
        while (busy && t < 4000) begin
            @(negedge clk);
            t++;
        end
        check("clr_done_busy", 32'(busy), 0);
        check("clr_done_cx", 32'(cursor_x), 0);
        check("clr_done_cy", 32'(cursor_y), 0);
        check("clr_done_base", 32'(row_base), 0);

        // Reset aborting a clear, dropping a queued status
        send(2'd0, 8'h71);
        send(2'd0, 8'h72);
        send(2'd3, 8'h00);
        repeat (99) @(negedge clk);
        status_valid = 1'b1;
        status_sel = 2'd2;
        @(negedge clk);
        check("abort_addr", 32'(tg_addr), 100);
        status_valid = 1'b0;
        rst_in = 1'b1;
        @(negedge clk);
        check("abort_we", 32'(tg_we), 0);
        check("abort_addr0", 32'(tg_addr), 0);
        check("abort_data0", 32'(tg_input), 0);
        check("abort_cx", 32'(cursor_x), 0);
        check("abort_cy", 32'(cursor_y), 0);
        check("abort_base", 32'(row_base), 0);
        check("abort_busy", 32'(busy), 0);
        rst_in = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_abort_we", 32'(tg_we), 0);
            check("post_abort_ready", 32'(cmd_ready), 1);
        end

        // Randomized traffic with random status requests
        rnd_en = 1;
        nclr = 0;
        for (int n = 0; n < 1500; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            r = $urandom_range(0, 99);
            if (r < 64) op = 2'd0;
            else if (r < 84) op = 2'd1;
            else if (r < 98 || nclr >= 2) op = 2'd2;
            else begin
                op = 2'd3;
                nclr++;
            end
            send(op, 8'($urandom_range(32, 126)));
        end
        rnd_en = 0;
        status_valid = 1'b0;
        t = 0;
        while ((busy || !cmd_ready) && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("drain_idle", 32'(busy), 0);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
